alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a sequential datapath: single-cycle arithmetic/logic, bit-serial shifts.
// Optional shift-add multiplier is built only when ALU_CTRL_SEQ_MUL_EN is defined.
module alu_ctrl_seq #(
    parameter int DATA_W = 16,
    parameter int FN_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        AluOp,
    input  logic [FN_W-1:0]   FnField,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [3:0]        AluCtrl,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              illegal
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_SLL = 4'b1000;
    localparam logic [3:0] CTRL_SRL = 4'b1001;
    localparam logic [3:0] CTRL_MUL = 4'b1010;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [3:0] decodeCtrl(input logic [1:0] op, input logic [1:0] fn);
        logic [3:0] ctrl;
        casez ({op, fn})
            4'b00??: ctrl = CTRL_ADD;
            4'b01??: ctrl = CTRL_SUB;
            4'b1000: ctrl = CTRL_ADD;
            4'b1001: ctrl = CTRL_SUB;
            4'b1010: ctrl = CTRL_AND;
            4'b1011: ctrl = CTRL_OR;
            4'b1100: ctrl = CTRL_SLL;
            4'b1101: ctrl = CTRL_SRL;
`ifdef ALU_CTRL_SEQ_MUL_EN
            4'b1110: ctrl = CTRL_MUL;
`else
            4'b1110: ctrl = CTRL_ILL;
`endif
            4'b1111: ctrl = CTRL_SLT;
            default: ctrl = CTRL_ILL;
        endcase
        return ctrl;
    endfunction

    // Shifts reaching this function have a zero amount, so they pass the operand through.
    function automatic logic [DATA_W-1:0] aluSingle(input logic [3:0] ctrl,
                                                    input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] res;
        case (ctrl)
            CTRL_ADD: res = x + y;
            CTRL_SUB: res = x - y;
            CTRL_AND: res = x & y;
            CTRL_OR:  res = x | y;
            CTRL_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(x) < $signed(y))};
            CTRL_SLL: res = x;
            CTRL_SRL: res = x;
            default:  res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    state_t            state_r, stateNext_s;
    logic [CNT_W-1:0]  cnt_r, cntNext_s;
    logic [DATA_W-1:0] work_r, workNext_s;
    logic [3:0]        ctrl_r, ctrlNext_s;
    logic [DATA_W-1:0] result_r, resultNext_s;
    logic              busy_r, busyNext_s;
    logic              done_r, doneNext_s;
    logic              zero_r, zeroNext_s;
    logic              illegal_r, illegalNext_s;
    logic [DATA_W-1:0] stepRes_s;
`ifdef ALU_CTRL_SEQ_MUL_EN
    logic [DATA_W-1:0] prod_r, prodNext_s;
    logic [DATA_W-1:0] mplier_r, mplierNext_s;
`endif

    logic [3:0]        decCtrl_s;
    logic [SH_W-1:0]   shAmt_s;
    logic [DATA_W-1:0] singleRes_s;
    logic              isShift_s;

    assign decCtrl_s   = decodeCtrl(AluOp, FnField[1:0]);
    assign shAmt_s     = b[SH_W-1:0];
    assign singleRes_s = aluSingle(decCtrl_s, a, b);
    assign isShift_s   = (decCtrl_s == CTRL_SLL) || (decCtrl_s == CTRL_SRL);

    // Next-state and next-output computation for the IDLE/ITER/DONE sequencer.
    always_comb begin
        stateNext_s   = state_r;
        cntNext_s     = cnt_r;
        workNext_s    = work_r;
        ctrlNext_s    = ctrl_r;
        resultNext_s  = result_r;
        busyNext_s    = busy_r;
        doneNext_s    = 1'b0;
        zeroNext_s    = zero_r;
        illegalNext_s = illegal_r;
        stepRes_s     = {DATA_W{1'b0}};
`ifdef ALU_CTRL_SEQ_MUL_EN
        prodNext_s    = prod_r;
        mplierNext_s  = mplier_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    ctrlNext_s    = decCtrl_s;
                    illegalNext_s = (decCtrl_s == CTRL_ILL);
                    workNext_s    = a;
                    if (isShift_s && (shAmt_s != {SH_W{1'b0}})) begin
                        stateNext_s = ITER;
                        busyNext_s  = 1'b1;
                        cntNext_s   = CNT_W'(shAmt_s);
                    end
`ifdef ALU_CTRL_SEQ_MUL_EN
                    else if (decCtrl_s == CTRL_MUL) begin
                        stateNext_s  = ITER;
                        busyNext_s   = 1'b1;
                        cntNext_s    = CNT_W'(DATA_W);
                        prodNext_s   = {DATA_W{1'b0}};
                        mplierNext_s = b;
                    end
`endif
                    else begin
                        stateNext_s  = DONE;
                        resultNext_s = singleRes_s;
                        zeroNext_s   = (singleRes_s == {DATA_W{1'b0}});
                        doneNext_s   = 1'b1;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ITER: begin
                if (ctrl_r == CTRL_SLL) begin
                    stepRes_s  = {work_r[DATA_W-2:0], 1'b0};
                    workNext_s = stepRes_s;
                end else if (ctrl_r == CTRL_SRL) begin
                    stepRes_s  = {1'b0, work_r[DATA_W-1:1]};
                    workNext_s = stepRes_s;
                end else begin
`ifdef ALU_CTRL_SEQ_MUL_EN
                    // Shift-add: work holds the shifted multiplicand, mplier the remaining multiplier bits.
                    stepRes_s    = mplier_r[0] ? (prod_r + work_r) : prod_r;
                    prodNext_s   = stepRes_s;
                    workNext_s   = {work_r[DATA_W-2:0], 1'b0};
                    mplierNext_s = {1'b0, mplier_r[DATA_W-1:1]};
`else
                    stepRes_s    = {DATA_W{1'b0}};
`endif
                end
                if (cnt_r == CNT_ONE) begin
                    stateNext_s  = DONE;
                    busyNext_s   = 1'b0;
                    doneNext_s   = 1'b1;
                    resultNext_s = stepRes_s;
                    zeroNext_s   = (stepRes_s == {DATA_W{1'b0}});
                    cntNext_s    = {CNT_W{1'b0}};
                end else begin
                    cntNext_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                stateNext_s = IDLE;
            end
            default: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            work_r    <= {DATA_W{1'b0}};
            ctrl_r    <= 4'b0000;
            result_r  <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            zero_r    <= 1'b0;
            illegal_r <= 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
            prod_r    <= {DATA_W{1'b0}};
            mplier_r  <= {DATA_W{1'b0}};
`endif
        end else begin
            state_r   <= stateNext_s;
            cnt_r     <= cntNext_s;
            work_r    <= workNext_s;
            ctrl_r    <= ctrlNext_s;
            result_r  <= resultNext_s;
            busy_r    <= busyNext_s;
            done_r    <= doneNext_s;
            zero_r    <= zeroNext_s;
            illegal_r <= illegalNext_s;
`ifdef ALU_CTRL_SEQ_MUL_EN
            prod_r    <= prodNext_s;
            mplier_r  <= mplierNext_s;
`endif
        end
    end

    assign AluCtrl = ctrl_r;
    assign result  = result_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign zero    = zero_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed literal cases plus randomized traffic
// compared every cycle against a latency/arithmetic model.
module tb_alu_ctrl_seq;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    AluOp;
    logic [1:0]    FnField;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    AluCtrl;
    logic [DW-1:0] result;
    logic          busy;
    logic          done;
    logic          zero;
    logic          illegal;

    int checks = 0;
    int passes = 0;
    bit chkEn  = 1'b0;

    alu_ctrl_seq #(.DATA_W(DW), .FN_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .AluOp(AluOp), .FnField(FnField),
        .a(a), .b(b), .AluCtrl(AluCtrl), .result(result), .busy(busy),
        .done(done), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setOp(input logic [1:0] op, input logic [1:0] fn,
                         input logic [DW-1:0] av, input logic [DW-1:0] bv);
        start = 1'b1; AluOp = op; FnField = fn; a = av; b = bv;
    endtask

    // Reference model: counts remaining busy cycles and computes results with plain arithmetic.
    int            mBusyLeft = 0;
    bit            mCooldown = 1'b0;
    logic [DW-1:0] mResult = '0, mPend = '0;
    logic          mZero = 1'b0, mDone = 1'b0, mBusy = 1'b0, mIll = 1'b0;
    logic [3:0]    mCtrl = 4'h0;

    always @(posedge clk) begin
        logic [DW-1:0] res;
        logic [3:0]    ctrl;
        int            lat;
        int            s;
        if (!rst_n) begin
            mBusyLeft = 0; mCooldown = 1'b0; mResult = '0; mZero = 1'b0;
            mDone = 1'b0; mBusy = 1'b0; mIll = 1'b0; mCtrl = 4'h0;
        end else begin
            mDone = 1'b0;
            if (mBusyLeft > 0) begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin
                    mBusy = 1'b0; mResult = mPend; mZero = (mPend == '0);
                    mDone = 1'b1; mCooldown = 1'b1;
                end
            end else if (mCooldown) begin
                mCooldown = 1'b0;
            end else if (start) begin
                s = int'(b[3:0]);
                lat = 0;
                res = '0;
                ctrl = 4'hF;
                if (AluOp == 2'd0 || (AluOp == 2'd2 && FnField == 2'd0)) begin
                    ctrl = 4'h2; res = a + b;
                end else if (AluOp == 2'd1 || (AluOp == 2'd2 && FnField == 2'd1)) begin
                    ctrl = 4'h6; res = a - b;
                end else if (AluOp == 2'd2 && FnField == 2'd2) begin
                    ctrl = 4'h0; res = a & b;
                end else if (AluOp == 2'd2) begin
                    ctrl = 4'h1; res = a | b;
                end else if (FnField == 2'd0) begin
                    ctrl = 4'h8; res = a << s; lat = s;
                end else if (FnField == 2'd1) begin
                    ctrl = 4'h9; res = a >> s; lat = s;
                end else if (FnField == 2'd3) begin
                    ctrl = 4'h7; res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                end else begin
`ifdef ALU_CTRL_SEQ_MUL_EN
                    ctrl = 4'hA; res = a * b; lat = DW;
`else
                    ctrl = 4'hF; res = '0;
`endif
                end
                mCtrl = ctrl;
                mIll = (ctrl == 4'hF);
                if (lat == 0) begin
                    mResult = res; mZero = (res == '0); mDone = 1'b1; mCooldown = 1'b1;
                end else begin
                    mBusyLeft = lat; mBusy = 1'b1; mPend = res;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkEn) begin
            chk("m_busy", 32'(busy), 32'(mBusy));
            chk("m_done", 32'(done), 32'(mDone));
            chk("m_ctrl", 32'(AluCtrl), 32'(mCtrl));
            chk("m_illegal", 32'(illegal), 32'(mIll));
            if (!mBusy) begin
                chk("m_result", 32'(result), 32'(mResult));
                chk("m_zero", 32'(zero), 32'(mZero));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        setOp(2'd0, 2'd0, 16'h0001, 16'h0001);
        // Reset held two cycles with start asserted.
        step();
        chk("rst_busy1", 32'(busy), 32'd0);
        step();
        chk("rst_busy2", 32'(busy), 32'd0);
        chk("rst_ctrl", 32'(AluCtrl), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chkEn = 1'b1;
        rst_n = 1'b1;
        start = 1'b0;
        step();

        // add overflow wrap into the sign bit
        setOp(2'd0, 2'd0, 16'h7FFF, 16'h0001);
        step(); start = 1'b0;
        chk("add_result", 32'(result), 32'h8000);
        chk("add_ctrl", 32'(AluCtrl), 32'h2);
        chk("add_done", 32'(done), 32'd1);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_busy", 32'(busy), 32'd0);
        step();
        chk("add_done_pulse", 32'(done), 32'd0);

        // beq-style subtract then signed slt
        setOp(2'd1, 2'd0, 16'h0005, 16'h0005);
        step(); start = 1'b0;
        chk("sub_result", 32'(result), 32'h0000);
        chk("sub_zero", 32'(zero), 32'd1);
        chk("sub_ctrl", 32'(AluCtrl), 32'h6);
        step();
        setOp(2'd3, 2'd3, 16'hFFFF, 16'h0001);
        step(); start = 1'b0;
        chk("slt_result", 32'(result), 32'h0001);
        chk("slt_ctrl", 32'(AluCtrl), 32'h7);
        step();

        // sll by 4 with a start pulse during busy
        setOp(2'd3, 2'd0, 16'h0003, 16'h0004);
        step(); start = 1'b0;
        chk("sll_busy0", 32'(busy), 32'd1);
        chk("sll_ctrl", 32'(AluCtrl), 32'h8);
        step();
        chk("sll_busy1", 32'(busy), 32'd1);
        setOp(2'd0, 2'd0, 16'h0000, 16'h0000);
        step(); start = 1'b0;
        chk("sll_busy2", 32'(busy), 32'd1);
        chk("sll_ignore_ctrl", 32'(AluCtrl), 32'h8);
        step();
        chk("sll_busy3", 32'(busy), 32'd1);
        chk("sll_no_early_done", 32'(done), 32'd0);
        step();
        chk("sll_done", 32'(done), 32'd1);
        chk("sll_result", 32'(result), 32'h0030);
        chk("sll_busy_end", 32'(busy), 32'd0);
        step();

        // mul or its illegal substitute
        setOp(2'd3, 2'd2, 16'h0012, 16'h0034);
        step(); start = 1'b0;
`ifdef ALU_CTRL_SEQ_MUL_EN
        for (int i = 1; i < DW; i++) begin
            chk("mul_busy", 32'(busy), 32'd1);
            step();
        end
        chk("mul_busy_last", 32'(busy), 32'd1);
        step();
        chk("mul_done", 32'(done), 32'd1);
        chk("mul_result", 32'(result), 32'h03A8);
        chk("mul_ctrl", 32'(AluCtrl), 32'hA);
`else
        chk("ill_result", 32'(result), 32'h0000);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_ctrl", 32'(AluCtrl), 32'hF);
        chk("ill_zero", 32'(zero), 32'd1);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
`endif
        step();
        setOp(2'd2, 2'd3, 16'h00F0, 16'h000F);
        step(); start = 1'b0;
        chk("or_result", 32'(result), 32'h00FF);
        chk("or_illegal_clr", 32'(illegal), 32'd0);
        step();

        // reset on the 5th busy cycle aborts the operation
`ifdef ALU_CTRL_SEQ_MUL_EN
        setOp(2'd3, 2'd2, 16'h0012, 16'h0034);
`else
        setOp(2'd3, 2'd0, 16'h0001, 16'h000F);
`endif
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_busy", 32'(busy), 32'd1);
            step();
        end
        rst_n = 1'b0;
        step();
        chk("abort_busy_clr", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ctrl", 32'(AluCtrl), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            start   = ($urandom_range(0, 2) == 0);
            AluOp   = 2'($urandom);
            FnField = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 16'h8000;
                1:       a = 16'($urandom_range(0, 7));
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
